// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            requesters. An owner keeps the port for up to BURST_MAX
//            consecutive words. After that, ownership rotates to the next
//            index. No word is granted while the FIFO reports full.
// Optional : macro FIFO_WR_ARBITER_STATS_EN adds per-requester saturating
//            16-bit grant counters on port grant_cnt.
// Ports    :
//   clk           in   clock, all logic on posedge
//   rst           in   synchronous active-high reset
//   req           in   [NUM_REQ]            level write requests
//   req_data      in   [NUM_REQ*FIFO_WIDTH] packed data, slice i = requester i
//   gnt           out  [NUM_REQ]            one-hot/zero grant (combinational)
//   fifo_write    out  FIFO write strobe (OR of gnt)
//   fifo_data_in  out  [FIFO_WIDTH]         granted slice, 0 when idle
//   fifo_full     in   FIFO full flag
//   busy          out  registered, 1 while a burst is in progress
//   owner         out  registered current/last owner index
//   grant_cnt     out  [NUM_REQ*16]         (stats build only) grant counts
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_write,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

  localparam int c_PW = $clog2(NUM_REQ);
  localparam int c_CW = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            r_state;
  logic [c_PW-1:0]   r_rr_ptr;
  logic [c_CW-1:0]   r_burst_cnt;
  logic [c_PW-1:0]   r_owner;
  logic              r_busy;

  logic              w_found;
  logic [c_PW-1:0]   w_winner;
  logic [c_PW:0]     w_sum;
  logic              w_grant_en;
  logic [c_PW-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [FIFO_WIDTH-1:0] w_data;

  // Index following i, wrapping from NUM_REQ-1 back to 0.
  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] i);
    if (i == c_PW'(NUM_REQ - 1))
      return '0;
    else
      return i + c_PW'(1);
  endfunction

  // Round-robin search starting at r_rr_ptr. One extra bit on the sum
  // lets the wrap be done with a single conditional subtract, so
  // NUM_REQ does not need to be a power of two.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_PW+1)'(k);
      if (w_sum >= (c_PW+1)'(NUM_REQ))
        w_sum = w_sum - (c_PW+1)'(NUM_REQ);
      if (!w_found && req[w_sum[c_PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[c_PW-1:0];
      end
    end
  end

  // Grant decision. It is combinational so that a request is granted in
  // the same cycle. Reset and fifo_full both suppress it unconditionally.
  always_comb begin
    w_grant_en  = 1'b0;
    w_grant_idx = '0;
    if (!rst && !fifo_full) begin
      if (r_state == S_IDLE) begin
        w_grant_en  = w_found;
        w_grant_idx = w_winner;
      end else begin
        w_grant_en  = req[r_owner];
        w_grant_idx = r_owner;
      end
    end
  end

  always_comb begin
    w_gnt  = '0;
    w_data = '0;
    if (w_grant_en)
      w_gnt = NUM_REQ'(1) << w_grant_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i])
        w_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  assign gnt          = w_gnt;
  assign fifo_write   = |w_gnt;
  assign fifo_data_in = w_data;
  assign busy         = r_busy;
  assign owner        = r_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_owner     <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found && !fifo_full) begin
            r_owner <= w_winner;
            if (BURST_MAX == 1) begin
              // Single-word bursts never leave IDLE. Rotate right away.
              r_rr_ptr <= f_next(w_winner);
            end else begin
              r_state     <= S_BURST;
              r_burst_cnt <= c_CW'(1);
              r_busy      <= 1'b1;
            end
          end
        end

        S_BURST: begin
          if (req[r_owner]) begin
            if (!fifo_full) begin
              if (r_burst_cnt == c_CW'(BURST_MAX - 1)) begin
                r_state     <= S_IDLE;
                r_rr_ptr    <= f_next(r_owner);
                r_burst_cnt <= '0;
                r_busy      <= 1'b0;
              end else begin
                r_burst_cnt <= r_burst_cnt + c_CW'(1);
              end
            end
            // fifo_full with the owner still requesting: hold everything.
          end else begin
            // The owner released early. This cycle is a bubble, and the
            // next owner is chosen from IDLE.
            r_state     <= S_IDLE;
            r_rr_ptr    <= f_next(r_owner);
            r_burst_cnt <= '0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_burst_cnt <= '0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    always_ff @(posedge clk) begin
      if (rst)
        r_grant_cnt[g] <= '0;
      else if (w_gnt[g] && (r_grant_cnt[g] != 16'hFFFF))
        r_grant_cnt[g] <= r_grant_cnt[g] + 16'd1;
    end
    assign grant_cnt[g*16 +: 16] = r_grant_cnt[g];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter (4 requesters, 8-bit
//            data, bursts of 4). Expected grant/data pairs are queued as the
//            stimulus is driven and then popped and compared mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_write;
  logic [7:0]  fifo_data_in;
  logic        fifo_full;
  logic        busy;
  logic [1:0]  owner;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];   // {gnt[3:0], data[7:0]}
  logic [11:0] e;

  fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(8), .BURST_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .busy         (busy),
    .owner        (owner)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; fifo_full = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; fifo_full = 1'b0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({4'b0000, 8'h00});
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (gnt !== e[11:8] || fifo_write !== 1'b0 || fifo_data_in !== e[7:0]) begin
        bad++;
        $display("FAIL reset_hold[%0d] gnt=%b wr=%b data=%h expected gnt=%b wr=0 data=%h",
                 k, gnt, fifo_write, fifo_data_in, e[11:8], e[7:0]);
      end
      next_cycle();
    end
    total++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      bad++;
      $display("FAIL reset_regs busy=%b owner=%0d expected busy=0 owner=0", busy, owner);
    end
    rst = 1'b0;
    exp_q.push_back({4'b0001, 8'hA0});
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (gnt !== e[11:8] || fifo_write !== 1'b1 || fifo_data_in !== e[7:0]) begin
      bad++;
      $display("FAIL reset_first gnt=%b wr=%b data=%h expected gnt=%b wr=1 data=%h",
               gnt, fifo_write, fifo_data_in, e[11:8], e[7:0]);
    end
    next_cycle();
    total++;
    if (busy !== 1'b1 || owner !== 2'd0) begin
      bad++;
      $display("FAIL reset_burst busy=%b owner=%0d expected busy=1 owner=0", busy, owner);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_lone_streamer();
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      req_data = {8'h00, 8'(8'h10 + k), 8'h55, 8'h66};
      exp_q.push_back({4'b0100, 8'(8'h10 + k)});
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (gnt !== e[11:8] || fifo_write !== 1'b1 || fifo_data_in !== e[7:0]) begin
        bad++;
        $display("FAIL stream[%0d] gnt=%b wr=%b data=%h expected gnt=%b wr=1 data=%h",
                 k, gnt, fifo_write, fifo_data_in, e[11:8], e[7:0]);
      end
      next_cycle();
    end
    total++;
    if (owner !== 2'd2) begin
      bad++;
      $display("FAIL stream_owner owner=%0d expected 2", owner);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_rotation();
    logic [1:0] idx;
    do_reset();
    req = 4'b1111;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 17; k++) begin
`ifdef FIFO_WR_ARBITER_STATS_EN
      if (k == 16) begin
        total++;
        if (grant_cnt !== {16'd4, 16'd4, 16'd4, 16'd4}) begin
          bad++;
          $display("FAIL stats_rotation grant_cnt=%h expected 0004000400040004", grant_cnt);
        end
      end
`endif
      idx = 2'((k / 4) % 4);
      exp_q.push_back({4'(4'b0001 << idx), 8'(8'hA0 + idx)});
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (gnt !== e[11:8] || fifo_write !== 1'b1 || fifo_data_in !== e[7:0]) begin
        bad++;
        $display("FAIL rotation[%0d] gnt=%b wr=%b data=%h expected gnt=%b wr=1 data=%h",
                 k, gnt, fifo_write, fifo_data_in, e[11:8], e[7:0]);
      end
      next_cycle();
    end
`ifdef FIFO_WR_ARBITER_STATS_EN
    rst = 1'b1; req = '0;
    next_cycle();
    rst = 1'b0;
    total++;
    if (grant_cnt !== 64'd0) begin
      bad++;
      $display("FAIL stats_reset grant_cnt=%h expected 0", grant_cnt);
    end
`endif
  endtask

  // ---------------------------------------------------------------------
  task automatic test_stall();
    logic [3:0] rq [10];
    logic       fl [10];
    logic [3:0] eg [10];
    rq = '{4'b0010, 4'b0010, 4'b0010, 4'b1111, 4'b1111, 4'b1111,
           4'b1111, 4'b1111, 4'b1111, 4'b1111};
    fl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    eg = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
           4'b0010, 4'b0010, 4'b0100, 4'b0100};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req = rq[k];
      fifo_full = fl[k];
      // Data keeps changing; ungranted cycles must still output 0.
      req_data = {8'(8'hC0 + k), 8'(8'hB0 + k), 8'(8'h90 + k), 8'(8'h80 + k)};
      case (eg[k])
        4'b0010: exp_q.push_back({eg[k], 8'(8'h90 + k)});
        4'b0100: exp_q.push_back({eg[k], 8'(8'hB0 + k)});
        default: exp_q.push_back({eg[k], 8'h00});
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (gnt !== e[11:8] || fifo_write !== (|e[11:8]) || fifo_data_in !== e[7:0]) begin
        bad++;
        $display("FAIL stall[%0d] gnt=%b wr=%b data=%h expected gnt=%b wr=%b data=%h",
                 k, gnt, fifo_write, fifo_data_in, e[11:8], |e[11:8], e[7:0]);
      end
      if (k == 0) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL stall_idle_full busy=%b expected 0", busy);
        end
      end
      if (k >= 3 && k <= 5) begin
        total++;
        if (busy !== 1'b1 || owner !== 2'd1) begin
          bad++;
          $display("FAIL stall_hold[%0d] busy=%b owner=%0d expected busy=1 owner=1",
                   k, busy, owner);
        end
      end
      next_cycle();
    end
    fifo_full = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_early_release();
    logic [3:0] rq [4];
    logic [3:0] eg [4];
    rq = '{4'b0001, 4'b0001, 4'b1000, 4'b1000};
    eg = '{4'b0001, 4'b0001, 4'b0000, 4'b1000};
    do_reset();
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    for (int k = 0; k < 4; k++) begin
      req = rq[k];
      case (eg[k])
        4'b0001: exp_q.push_back({eg[k], 8'hD0});
        4'b1000: exp_q.push_back({eg[k], 8'hD3});
        default: exp_q.push_back({eg[k], 8'h00});
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (gnt !== e[11:8] || fifo_write !== (|e[11:8]) || fifo_data_in !== e[7:0]) begin
        bad++;
        $display("FAIL release[%0d] gnt=%b wr=%b data=%h expected gnt=%b wr=%b data=%h",
                 k, gnt, fifo_write, fifo_data_in, e[11:8], |e[11:8], e[7:0]);
      end
      next_cycle();
    end
    total++;
    if (owner !== 2'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL release_owner owner=%0d busy=%b expected owner=3 busy=1", owner, busy);
    end
  endtask

  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    test_reset();
    test_lone_streamer();
    test_rotation();
    test_stall();
    test_early_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo write port between num_req requesters.
- Grants the port in bursts of at most burst_max words per requester, then rotates ownership.
- Stalls on fifo_full, so the FIFO is never written while full.
- Sits directly in front of the FIFO's fifo_write / fifo_data_in / fifo_full interface.

Parameters:
num_req, 4, number of requesters; legal range 2..16.
fifo_width, 8, data word width; must match the FIFO.
burst_max, 4, maximum consecutive grants to one owner before rotation; legal range 1..255.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
req  input  num_req  per-requester write request; level, held until granted.
req_data  input  num_req*fifo_width  packed data; slice i belongs to requester i.
gnt  output  num_req  one-hot or zero; gnt[i]=1 means req_data slice i is written this cycle.
fifo_write  output  1  write strobe to FIFO; equals OR of gnt.
fifo_data_in  output  fifo_width  granted requester's data slice; 0 when no grant.
fifo_full  input  1  FIFO full flag.
busy  output  1  registered; 1 while in BURST state.
owner  output  $clog2(num_req)  registered current or last owner index.

Behaviour:
Reset and timing:
- Reset is synchronous, active-high. While rst=1, gnt=0 and fifo_write=0 regardless of inputs.
- At the posedge with rst=1: state=IDLE, rr_ptr=0, burst_cnt=0, owner=0, busy=0.
- gnt, fifo_write and fifo_data_in are combinational from state, req and fifo_full. Latency from req to grant is 0 cycles.
- Grant never issued when fifo_full=1.

State IDLE:
- Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo num_req.
- If a winner exists and fifo_full=0: gnt[winner]=1 and owner<=winner.
  - burst_max==1: stay IDLE, rr_ptr<=winner+1 (mod num_req).
  - Otherwise: go to BURST with burst_cnt<=1.
- If no req, or fifo_full=1: no grant, no state change.

State BURST (owner locked):
- req[owner]=1 and fifo_full=0: gnt[owner]=1, burst_cnt++.
  - If the incremented count equals burst_max: go to IDLE, rr_ptr<=owner+1 (mod num_req), burst_cnt<=0.
- req[owner]=1 and fifo_full=1: stall. No grant; state, burst_cnt and owner held.
- req[owner]=0: no grant this cycle (one bubble). Go to IDLE, rr_ptr<=owner+1, burst_cnt<=0.
- Requests from non-owners are ignored while in BURST.

Boundary conditions:
- Wrap: owner num_req-1 gives rr_ptr 0.
- A lone continuous requester is re-granted from IDLE immediately after burst end, so there is no bubble.
- burst_cnt width is $clog2(burst_max+1).
- rst asserted mid-burst: next cycle is IDLE, rr_ptr=0. A word granted in the same cycle as rst does not occur, because gnt is forced to 0.
- req_data changes without a grant are ignored.
- busy is 1 exactly in BURST.

Optional Feature:
Macro FIFO_WR_ARBITER_STATS_EN.
- Defined: adds output port grant_cnt, num_req*16 bits.
  - Slice i counts grants to requester i and saturates at 16'hFFFF.
  - Cleared to 0 by rst; updated at the posedge following each gnt[i].
- Not defined: port and counters are absent. Arbitration behaviour is identical in both cases.

Test Plan:
1. Reset: rst=1 for 3 cycles, req=4'b1111, fifo_full=0 -> gnt=0, fifo_write=0 throughout. First cycle after rst=0 -> gnt=4'b0001, fifo_data_in=req_data[7:0].
2. Lone streamer: only req[2]=1 continuously, fifo_full=0, data incrementing 0x10.. -> fifo_write=1 every cycle, gnt=4'b0100. Words 0x10,0x11,... written without gaps; owner=2.
3. Full rotation: req=4'b1111 for 16 cycles, burst_max=4 -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3. Cycle 17 -> grant to 0.
4. Full stall: req[1] owns after 2 words; fifo_full=1 for 3 cycles -> gnt=0, fifo_write=0, busy=1, owner=1, burst_cnt=2 held. fifo_full=0 -> 2 more grants to 1, then rotation to next requester.
5. Early release: req[0] drops after 2 grants, req[3]=1 -> one cycle with no grant, then gnt=4'b1000. Ownership passes to 3; with req[1] and req[2] idle, rr scan 1,2,3 selects 3.
6. Stats (FIFO_WR_ARBITER_STATS_EN): run scenario 3 -> grant_cnt slices = 4,4,4,4. Assert rst -> all slices 0.
